// File: rtl/tick_monitor.sv
// ---------------------------------------------------------------------------
// tick_monitor
//
// Receive-side checker for a periodic single-cycle tick stream. Measures the
// number of clk edges between consecutive tick-high samples, reports each
// measurement on period/period_valid, flags ticks that arrive too early or
// not at all, and asserts locked after LOCK_COUNT consecutive in-window
// intervals.
//
// Build option:
//   TICK_MON_STICKY_EN - adds input err_clr. err_early/err_late become sticky
//                        levels held until the cycle after err_clr=1 (a new
//                        error in the clearing cycle wins). err_clr also
//                        zeroes err_count.
//
// Ports:
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   en           in   monitor enable; 0 forces HUNT and clears counters
//   tick         in   tick under test, one sample per clk
//   err_clr      in   (TICK_MON_STICKY_EN only) clear sticky errors/count
//   period       out  last measured interval, held until next measurement
//   period_valid out  one-cycle pulse when period updates
//   locked       out  high while LOCK_COUNT+ consecutive good intervals seen
//   err_early    out  interval shorter than EXP_PERIOD-TOL
//   err_late     out  no tick by EXP_PERIOD+TOL cycles
//   err_count    out  errors since reset, saturating at 255
// ---------------------------------------------------------------------------
module tick_monitor #(
    parameter int EXP_PERIOD = 10,
    parameter int TOL        = 1,
    parameter int CW         = 8,
    parameter int LOCK_COUNT = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    input  logic          tick,
`ifdef TICK_MON_STICKY_EN
    input  logic          err_clr,
`endif
    output logic [CW-1:0] period,
    output logic          period_valid,
    output logic          locked,
    output logic          err_early,
    output logic          err_late,
    output logic [7:0]    err_count
);

    // Lower window edge clamps at 0 so a large TOL cannot wrap.
    localparam int            LO_INT = (EXP_PERIOD > TOL) ? (EXP_PERIOD - TOL) : 0;
    localparam logic [CW-1:0] WIN_LO = CW'(LO_INT);
    localparam logic [CW-1:0] WIN_HI = CW'(EXP_PERIOD + TOL);
    localparam int            GW     = $clog2(LOCK_COUNT + 1);
    localparam logic [GW-1:0] LOCK_C = GW'(LOCK_COUNT);

    typedef enum logic {
        HUNT    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] good_q, good_d;
    logic          locked_q, locked_d;
    logic [CW-1:0] period_q, period_d;
    logic          period_valid_q, period_valid_d;
    logic          err_early_q, err_early_d;
    logic          err_late_q, err_late_d;
    logic [7:0]    err_count_q, err_count_d;
    logic          early_evt;
    logic          late_evt;

    function automatic logic [CW-1:0] sat_inc_cnt(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Next-state and measurement logic
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        good_d         = good_q;
        locked_d       = locked_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        early_evt      = 1'b0;
        late_evt       = 1'b0;

        if (!en) begin
            state_d  = HUNT;
            cnt_d    = '0;
            good_d   = '0;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                HUNT: begin
                    if (tick) begin
                        state_d = MEASURE;
                        cnt_d   = CW'(1);
                    end
                end
                MEASURE: begin
                    if (tick) begin
                        // cnt_q holds the edges since the previous tick.
                        cnt_d          = CW'(1);
                        period_d       = cnt_q;
                        period_valid_d = 1'b1;
                        if (cnt_q < WIN_LO) begin
                            early_evt = 1'b1;
                            good_d    = '0;
                            locked_d  = 1'b0;
                        end else begin
                            good_d = (good_q >= LOCK_C) ? LOCK_C : good_q + GW'(1);
                            if (good_d == LOCK_C) begin
                                locked_d = 1'b1;
                            end
                        end
                    end else if (cnt_q >= WIN_HI) begin
                        // A tick at cnt == WIN_HI is still in-window; only
                        // its absence at that point is a timeout.
                        late_evt = 1'b1;
                        good_d   = '0;
                        locked_d = 1'b0;
                        state_d  = HUNT;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = sat_inc_cnt(cnt_q);
                    end
                end
                default: begin
                    state_d = HUNT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Error flags and error counter
    always_comb begin
        err_early_d = early_evt;
        err_late_d  = late_evt;
        err_count_d = err_count_q;
`ifdef TICK_MON_STICKY_EN
        // Set wins over a clear in the same cycle.
        err_early_d = early_evt | (err_early_q & ~err_clr);
        err_late_d  = late_evt | (err_late_q & ~err_clr);
        if (err_clr) begin
            err_count_d = 8'd0;
        end
`endif
        if (early_evt || late_evt) begin
            err_count_d = sat_inc8(err_count_d);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= HUNT;
            cnt_q          <= '0;
            good_q         <= '0;
            locked_q       <= 1'b0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            err_early_q    <= 1'b0;
            err_late_q     <= 1'b0;
            err_count_q    <= 8'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            good_q         <= good_d;
            locked_q       <= locked_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            err_early_q    <= err_early_d;
            err_late_q     <= err_late_d;
            err_count_q    <= err_count_d;
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;
    assign err_early    = err_early_q;
    assign err_late     = err_late_q;
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_tick_monitor.sv
// ---------------------------------------------------------------------------
// tb_tick_monitor
//
// Scoreboard bench for tick_monitor (default build). The driver issues one
// tick/en sample per cycle and, at the same time, advances a reference model
// that works from tick timestamps: it remembers the cycle of the last tick,
// takes the interval as a difference of cycle numbers, and pushes the
// expected period/error event into a queue. A separate monitor samples the
// DUT just after each rising edge and pops/compares whenever an event is
// shown, and also compares locked/period/err_count every cycle.
// ---------------------------------------------------------------------------
module tb_tick_monitor;

    localparam int EXP = 10;
    localparam int TOL = 1;
    localparam int CW  = 8;
    localparam int LC  = 3;
    localparam int LO  = EXP - TOL;
    localparam int HI  = EXP + TOL;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          en;
    logic          tick;
`ifdef TICK_MON_STICKY_EN
    logic          err_clr = 1'b0;
`endif
    logic [CW-1:0] period;
    logic          period_valid;
    logic          locked;
    logic          err_early;
    logic          err_late;
    logic [7:0]    err_count;

    always #5 clk = ~clk;

    tick_monitor #(
        .EXP_PERIOD(EXP),
        .TOL       (TOL),
        .CW        (CW),
        .LOCK_COUNT(LC)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .tick        (tick),
`ifdef TICK_MON_STICKY_EN
        .err_clr     (err_clr),
`endif
        .period      (period),
        .period_valid(period_valid),
        .locked      (locked),
        .err_early   (err_early),
        .err_late    (err_late),
        .err_count   (err_count)
    );

    typedef struct {
        int due;
        bit pv;
        bit early;
        bit late;
    } ev_t;

    ev_t evq[$];
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;

    // Reference model state (time-stamp based)
    bit  m_hunt   = 1'b1;
    int  m_last   = 0;
    int  m_good   = 0;
    bit  m_locked = 1'b0;
    int  m_period = 0;
    int  m_errc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, exp_v);
        end
    endtask

    task automatic model_reset();
        m_hunt   = 1'b1;
        m_good   = 0;
        m_locked = 1'b0;
        m_period = 0;
        m_errc   = 0;
        evq.delete();
    endtask

    // Called while driving the sample that the next rising edge will see.
    task automatic model_step(input bit en_v, input bit t);
        int  due;
        int  iv;
        ev_t e;
        if (!reset_n) return;
        due = cyc + 1;
        e.due = due; e.pv = 1'b0; e.early = 1'b0; e.late = 1'b0;
        if (!en_v) begin
            m_hunt   = 1'b1;
            m_good   = 0;
            m_locked = 1'b0;
        end else if (m_hunt) begin
            if (t) begin
                m_hunt = 1'b0;
                m_last = due;
            end
        end else begin
            iv = due - m_last;
            if (t) begin
                e.pv     = 1'b1;
                m_period = iv;
                m_last   = due;
                if (iv < LO) begin
                    e.early  = 1'b1;
                    m_good   = 0;
                    m_locked = 1'b0;
                    if (m_errc < 255) m_errc++;
                end else begin
                    m_good = (m_good + 1 > LC) ? LC : m_good + 1;
                    if (m_good >= LC) m_locked = 1'b1;
                end
                evq.push_back(e);
            end else if (iv >= HI) begin
                e.late   = 1'b1;
                m_hunt   = 1'b1;
                m_good   = 0;
                m_locked = 1'b0;
                if (m_errc < 255) m_errc++;
                evq.push_back(e);
            end
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge
    initial begin
        ev_t e;
        forever begin
            @(posedge clk);
            #1;
            chk("locked", int'(locked), int'(m_locked));
            chk("period", int'(period), m_period);
            chk("err_count", int'(err_count), m_errc);
            if (period_valid || err_early || err_late) begin
                checks++;
                if (evq.size() == 0 || evq[0].due != cyc) begin
                    failures++;
                    $display("FAIL unexpected_event cyc=%0d actual pv=%0b early=%0b late=%0b expected none",
                             cyc, period_valid, err_early, err_late);
                end else begin
                    e = evq.pop_front();
                    if (period_valid != e.pv || err_early != e.early || err_late != e.late) begin
                        failures++;
                        $display("FAIL event_kind cyc=%0d actual pv=%0b early=%0b late=%0b expected pv=%0b early=%0b late=%0b",
                                 cyc, period_valid, err_early, err_late, e.pv, e.early, e.late);
                    end
                end
            end else if (evq.size() != 0 && evq[0].due <= cyc) begin
                checks++;
                failures++;
                e = evq.pop_front();
                $display("FAIL missing_event cyc=%0d actual none expected pv=%0b early=%0b late=%0b",
                         cyc, e.pv, e.early, e.late);
            end
        end
    end

    // Driver helpers: called right after a falling edge, return at the next one.
    task automatic drive(input bit t);
        tick = t;
        model_step(en, t);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0);
    endtask

    // Tick that ends an interval of iv cycles from the previous tick.
    task automatic gap(input int iv);
        idle(iv - 1);
        drive(1'b1);
    endtask

    initial begin
        int r;
        reset_n = 1'b1;
        en      = 1'b0;
        tick    = 1'b0;
        #1;
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        en      = 1'b1;

        // Nominal stream, lock on 4th tick
        drive(1'b1);
        repeat (5) gap(10);

        // Early tick, then relock
        gap(7);
        repeat (3) gap(10);

        // Stream stops: timeout, then restart and relock
        idle(20);
        drive(1'b1);
        repeat (3) gap(10);

        // Window edges
        gap(9); gap(11); gap(11);
        gap(8);
        repeat (3) gap(11);

        // Enable dropped while ticks continue
        idle(4);
        en = 1'b0;
        for (int i = 0; i < 30; i++) drive((i % 7) == 3);
        en = 1'b1;
        gap(3);
        repeat (3) gap(10);

        // Randomised intervals with occasional dropouts and enable pulses
        repeat (150) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                en = 1'b0;
                idle($urandom_range(1, 5));
                en = 1'b1;
            end else if (r == 1) begin
                idle($urandom_range(12, 25));
            end else begin
                gap($urandom_range(1, 13));
            end
        end

        // Asynchronous reset mid-interval
        drive(1'b1);
        repeat (3) gap(10);
        idle(4);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("rst_period", int'(period), 0);
        chk("rst_period_valid", int'(period_valid), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_err_early", int'(err_early), 0);
        chk("rst_err_late", int'(err_late), 0);
        chk("rst_err_count", int'(err_count), 0);
        @(negedge clk);
        idle(2);
        reset_n = 1'b1;
        drive(1'b1);
        repeat (3) gap(10);
        idle(15);

        @(posedge clk);
        #2;
        chk("queue_empty", evq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
